// File: rtl/isdu_pkg.sv
// rtl/isdu_pkg.sv - shared types, opcodes, mux encodings and output decode for isdu_seq
//
// Purpose: state enumeration, control-word struct, opcode and mux-select
//          constants, and the state-to-control-word decode used by isdu_seq.
// Ports:   none (package).

package isdu_pkg;

  typedef enum logic [4:0] {
    S_HALTED,
    S_FETCH,
    S_RD,
    S_CAP,
    S_IRLD,
    S_DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    S_BR_TAKEN,
    S_JMP,
    S_LINK,
    S_JSR_T,
    S_LEA,
    S_EA,
    S_WB,
    S_SRC,
    S_WR,
    S_PAUSE1,
    S_PAUSE2
  } state_t;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       drmux;
    logic       sr1mux;
    logic       sr2mux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe;
    logic       mem_we;
  } ctrl_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;
  localparam logic [3:0] OP_LEA   = 4'b1110;

  localparam logic [1:0] PCMUX_PC1  = 2'b00;
  localparam logic [1:0] PCMUX_ADDR = 2'b01;
  localparam logic [1:0] PCMUX_BUS  = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  // Control word for a state. IR bits are stable for the whole instruction,
  // so folding them in keeps the outputs a pure function of the state.
  function automatic ctrl_t decode_ctrl(state_t s, logic ir_5, logic ir_11);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.ld_pc   = 1'b1;
        c.pcmux   = PCMUX_PC1;
      end
      S_RD: c.mem_oe = 1'b1;
      S_CAP: begin
        c.mem_oe = 1'b1;
        c.ld_mdr = 1'b1;
      end
      S_IRLD: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      S_DECODE: c.ld_ben = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
        c.drmux    = 1'b1;
        c.sr2mux   = ir_5;
        c.aluk     = (s == S_AND) ? ALUK_AND : (s == S_NOT) ? ALUK_NOT : ALUK_ADD;
      end
      S_BR_TAKEN: begin
        c.pcmux    = PCMUX_ADDR;
        c.addr2mux = ADDR2_OFF9;
        c.ld_pc    = 1'b1;
      end
      S_JMP: begin
        c.pcmux    = PCMUX_ADDR;
        c.addr1mux = 1'b1;
        c.addr2mux = ADDR2_ZERO;
        c.ld_pc    = 1'b1;
      end
      S_LINK: begin
        c.gate_pc = 1'b1;
        c.ld_reg  = 1'b1;
        c.drmux   = 1'b0;
      end
      S_JSR_T: begin
        c.pcmux = PCMUX_ADDR;
        c.ld_pc = 1'b1;
        if (ir_11) begin
          c.addr1mux = 1'b0;
          c.addr2mux = ADDR2_OFF11;
        end else begin
          c.addr1mux = 1'b1;
          c.addr2mux = ADDR2_ZERO;
        end
      end
      S_LEA: begin
        c.gate_marmux = 1'b1;
        c.addr2mux    = ADDR2_OFF9;
        c.ld_reg      = 1'b1;
        c.ld_cc       = 1'b1;
        c.drmux       = 1'b1;
      end
      S_EA: begin
        c.ld_mar      = 1'b1;
        c.gate_marmux = 1'b1;
        c.addr1mux    = 1'b1;
        c.addr2mux    = ADDR2_OFF6;
      end
      S_WB: begin
        c.gate_mdr = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
        c.drmux    = 1'b1;
      end
      S_SRC: begin
        // Store data is SR (IR[11:9]) passed through the ALU into MDR.
        c.sr1mux   = 1'b1;
        c.aluk     = ALUK_PASSA;
        c.gate_alu = 1'b1;
        c.ld_mdr   = 1'b1;
      end
      S_WR: c.mem_we = 1'b1;
      S_PAUSE1: c.ld_led = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/isdu_wait_ctr.sv
// rtl/isdu_wait_ctr.sv - memory wait-state down-counter shared by reads and writes
//
// Purpose: 4-bit counter loaded on entry to a memory wait state and
//          decremented while waiting; zero_o marks the final wait cycle.
// Ports:   clk_i, reset_i (sync, active-high), load_i/load_val_i (load
//          value), dec_i (decrement, saturates at 0), zero_o (count is 0).

module isdu_wait_ctr (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/isdu_seq.sv
// rtl/isdu_seq.sv - LC-3 instruction sequencer/decoder with configurable memory waits
//
// Purpose: Moore FSM driving datapath loads, bus gates, mux selects and the
//          SRAM strobes. Optional ready handshake selected by ISDU_MEM_RDY_EN:
//          when defined, reads and writes also wait for mem_rdy_i=1 once the
//          wait counter reaches 0; when undefined, mem_rdy_i is ignored.
// Ports:   clk_i, reset_i (sync, active-high), run_i, continue_i,
//          opcode_i (IR[15:12]), ir_5_i, ir_11_i, ben_i, mem_rdy_i;
//          ld_*_o load enables, gate_*_o bus drivers, mux selects
//          (pcmux_o, drmux_o, sr1mux_o, sr2mux_o, addr1mux_o, addr2mux_o,
//          aluk_o), mem_oe_o / mem_we_o SRAM strobes.

module isdu_seq
  import isdu_pkg::*;
#(
  parameter int unsigned RD_WAIT     = 2,
  parameter int unsigned WR_WAIT     = 1,
  parameter int unsigned PAUSE_FETCH = 0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       run_i,
  input  logic       continue_i,
  input  logic [3:0] opcode_i,
  input  logic       ir_5_i,
  input  logic       ir_11_i,
  input  logic       ben_i,
  input  logic       mem_rdy_i,
  output logic       ld_mar_o,
  output logic       ld_mdr_o,
  output logic       ld_ir_o,
  output logic       ld_ben_o,
  output logic       ld_cc_o,
  output logic       ld_reg_o,
  output logic       ld_pc_o,
  output logic       ld_led_o,
  output logic       gate_pc_o,
  output logic       gate_mdr_o,
  output logic       gate_alu_o,
  output logic       gate_marmux_o,
  output logic [1:0] pcmux_o,
  output logic       drmux_o,
  output logic       sr1mux_o,
  output logic       sr2mux_o,
  output logic       addr1mux_o,
  output logic [1:0] addr2mux_o,
  output logic [1:0] aluk_o,
  output logic       mem_oe_o,
  output logic       mem_we_o
);

  // RD holds Mem_OE for RD_WAIT cycles and exits when the counter is 0,
  // so it is loaded with one less than the depth. WR exits on 0 after
  // 1+WR_WAIT cycles, so it is loaded with the depth itself.
  localparam logic [3:0] RD_LOAD = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT);

`ifdef ISDU_MEM_RDY_EN
  // With the handshake, every read passes through RD so ready is sampled.
  localparam bit RD_SKIP = 1'b0;
  logic mem_ok;
  assign mem_ok = mem_rdy_i;
`else
  localparam bit RD_SKIP = (RD_WAIT == 0);
  logic mem_ok;
  logic unused_mem_rdy;
  assign mem_ok         = 1'b1;
  assign unused_mem_rdy = mem_rdy_i;
`endif

  state_t state_q, state_d;
  logic   data_rd_q, data_rd_d;   // current read is an LDR operand, not a fetch
  ctrl_t  ctrl_q, ctrl;
  logic   ctr_load, ctr_dec, ctr_zero;
  logic [3:0] ctr_load_val;

  isdu_wait_ctr u_wait_ctr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (ctr_load),
    .load_val_i (ctr_load_val),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero)
  );

  always_comb begin
    state_d      = state_q;
    data_rd_d    = data_rd_q;
    ctr_load     = 1'b0;
    ctr_load_val = RD_LOAD;
    ctr_dec      = 1'b0;
    case (state_q)
      S_HALTED: if (run_i) state_d = S_FETCH;
      S_FETCH: begin
        data_rd_d = 1'b0;
        if (RD_SKIP) begin
          state_d = S_CAP;
        end else begin
          state_d  = S_RD;
          ctr_load = 1'b1;
        end
      end
      S_RD: begin
        ctr_dec = 1'b1;
        if (ctr_zero && mem_ok) state_d = S_CAP;
      end
      S_CAP: state_d = data_rd_q ? S_WB : S_IRLD;
      S_IRLD: state_d = (PAUSE_FETCH != 0) ? S_PAUSE1 : S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_ADD:         state_d = S_ADD;
          OP_AND:         state_d = S_AND;
          OP_NOT:         state_d = S_NOT;
          OP_BR:          state_d = ben_i ? S_BR_TAKEN : S_FETCH;
          OP_JMP:         state_d = S_JMP;
          OP_JSR:         state_d = S_LINK;
          OP_LEA:         state_d = S_LEA;
          OP_LDR, OP_STR: state_d = S_EA;
          OP_PAUSE:       state_d = S_PAUSE1;
          default:        state_d = S_FETCH;
        endcase
      end
      S_LINK: state_d = S_JSR_T;
      S_EA: begin
        if (opcode_i == OP_STR) begin
          state_d = S_SRC;
        end else begin
          data_rd_d = 1'b1;
          if (RD_SKIP) begin
            state_d = S_CAP;
          end else begin
            state_d  = S_RD;
            ctr_load = 1'b1;
          end
        end
      end
      S_SRC: begin
        state_d      = S_WR;
        ctr_load     = 1'b1;
        ctr_load_val = WR_LOAD;
      end
      S_WR: begin
        ctr_dec = 1'b1;
        if (ctr_zero && mem_ok) state_d = S_FETCH;
      end
      S_PAUSE1: if (continue_i) state_d = S_PAUSE2;
      S_PAUSE2: if (!continue_i) state_d = S_FETCH;
      S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP, S_JSR_T, S_LEA, S_WB:
        state_d = S_FETCH;
      default: state_d = S_HALTED;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_HALTED;
      data_rd_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      data_rd_q <= data_rd_d;
      ctrl_q    <= decode_ctrl(state_d, ir_5_i, ir_11_i);
    end
  end

  // Reset masks the registered word so SRAM strobes drop in the reset cycle.
  assign ctrl = reset_i ? '0 : ctrl_q;

  assign ld_mar_o      = ctrl.ld_mar;
  assign ld_mdr_o      = ctrl.ld_mdr;
  assign ld_ir_o       = ctrl.ld_ir;
  assign ld_ben_o      = ctrl.ld_ben;
  assign ld_cc_o       = ctrl.ld_cc;
  assign ld_reg_o      = ctrl.ld_reg;
  assign ld_pc_o       = ctrl.ld_pc;
  assign ld_led_o      = ctrl.ld_led;
  assign gate_pc_o     = ctrl.gate_pc;
  assign gate_mdr_o    = ctrl.gate_mdr;
  assign gate_alu_o    = ctrl.gate_alu;
  assign gate_marmux_o = ctrl.gate_marmux;
  assign pcmux_o       = ctrl.pcmux;
  assign drmux_o       = ctrl.drmux;
  assign sr1mux_o      = ctrl.sr1mux;
  assign sr2mux_o      = ctrl.sr2mux;
  assign addr1mux_o    = ctrl.addr1mux;
  assign addr2mux_o    = ctrl.addr2mux;
  assign aluk_o        = ctrl.aluk;
  assign mem_oe_o      = ctrl.mem_oe;
  assign mem_we_o      = ctrl.mem_we;

endmodule
